// File: rtl/log_pkg.sv
// log_pkg: shared state encoding and defaults for the log RAM readout path.
package log_pkg;

    localparam int LOG_NB_ADDR = 10;
    localparam int LOG_NB_DATA = 8;

    // Edges from o_rd_en to usable i_rd_data. The READ -> WAIT pair spans this.
    localparam int RAM_RD_LAT = 1;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        PRESENT,
        CHKSUM,
        DONE
    } log_state_t;

endpackage

// File: rtl/log_stream_out_reg.sv
// log_stream_out_reg: registered data/valid holding stage of the readout stream.
// A load strobe captures a word and raises valid; the word is held until the
// consumer accepts it. o_fire marks the edge on which the transfer happens.
module log_stream_out_reg
    import log_pkg::*;
#(
    parameter int NB_DATA = LOG_NB_DATA
) (
    input  logic               clock,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic               i_load,
    input  logic [NB_DATA-1:0] i_load_data,
    input  logic               i_ready,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_valid,
    output logic               o_fire
);

    // A frozen stage never completes a handshake, even with ready high.
    assign o_fire = o_valid & i_ready & i_enable;

    // Hold the word until accepted; a load on the accepting edge wins.
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            o_data  <= '0;
            o_valid <= 1'b0;
        end else if (i_enable) begin
            if (i_load) begin
                o_data  <= i_load_data;
                o_valid <= 1'b1;
            end else if (o_fire) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/log_ram_reader.sv
// log_ram_reader: drains the data-logging BRAM after capture, words 0..last in
// order, through the RAM's synchronous read port onto a valid/ready stream.
// Optional build macro LOG_READER_CHECKSUM_EN appends an XOR checksum word.
module log_ram_reader
    import log_pkg::*;
#(
    parameter int NB_ADDR = LOG_NB_ADDR,
    parameter int NB_DATA = LOG_NB_DATA
) (
    input  logic               clock,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic               i_start,
    input  logic [NB_ADDR-1:0] i_last_addr,
    output logic               o_rd_en,
    output logic [NB_ADDR-1:0] o_rd_addr,
    input  logic [NB_DATA-1:0] i_rd_data,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_valid,
    input  logic               i_ready,
    output logic               o_busy,
    output logic               o_done
);

    log_state_t         state_q, state_d;
    logic [NB_ADDR-1:0] last_q, last_d;
    logic [NB_ADDR-1:0] rd_addr_q, rd_addr_d;
    logic               rd_en_q, rd_en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               load;
    logic [NB_DATA-1:0] load_data;
    logic               fire;
`ifdef LOG_READER_CHECKSUM_EN
    logic [NB_DATA-1:0] acc_q, acc_d;
`endif

    // Next-state and next-register values for the readout sequencer.
    // NOTE: every signal gets a default before the case, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        rd_addr_d = rd_addr_q;
        rd_en_d   = rd_en_q;
        load      = 1'b0;
        load_data = i_rd_data;
`ifdef LOG_READER_CHECKSUM_EN
        acc_d     = acc_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (i_start) begin
                    last_d    = i_last_addr;
                    rd_addr_d = '0;
                    rd_en_d   = 1'b1;
`ifdef LOG_READER_CHECKSUM_EN
                    acc_d     = '0;
`endif
                    state_d   = READ;
                end
            end
            READ: begin
                // The RAM registers its output on this edge.
                rd_en_d = 1'b0;
                state_d = WAIT;
            end
            WAIT: begin
                load    = 1'b1;
                state_d = PRESENT;
            end
            PRESENT: begin
                if (fire) begin
`ifdef LOG_READER_CHECKSUM_EN
                    acc_d = acc_q ^ o_data;
`endif
                    // Termination is checked before the increment, so the address never wraps.
                    if (rd_addr_q == last_q) begin
`ifdef LOG_READER_CHECKSUM_EN
                        load      = 1'b1;
                        load_data = acc_q ^ o_data;
                        state_d   = CHKSUM;
`else
                        state_d   = DONE;
`endif
                    end else begin
                        rd_addr_d = rd_addr_q + NB_ADDR'(1);
                        rd_en_d   = 1'b1;
                        state_d   = READ;
                    end
                end
            end
`ifdef LOG_READER_CHECKSUM_EN
            CHKSUM: begin
                if (fire) begin
                    state_d = DONE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
        // Status flags are registered from the next state so they line up with it.
        busy_d = (state_d != IDLE) && (state_d != DONE);
        done_d = (state_d == DONE);
    end

    // State and control registers; everything holds while i_enable is low.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= IDLE;
            last_q    <= '0;
            rd_addr_q <= '0;
            rd_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef LOG_READER_CHECKSUM_EN
            acc_q     <= '0;
`endif
        end else if (i_enable) begin
            state_q   <= state_d;
            last_q    <= last_d;
            rd_addr_q <= rd_addr_d;
            rd_en_q   <= rd_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef LOG_READER_CHECKSUM_EN
            acc_q     <= acc_d;
`endif
        end
    end

    log_stream_out_reg #(
        .NB_DATA (NB_DATA)
    ) u_stream_out (
        .clock       (clock),
        .i_reset     (i_reset),
        .i_enable    (i_enable),
        .i_load      (load),
        .i_load_data (load_data),
        .i_ready     (i_ready),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_fire      (fire)
    );

    assign o_rd_en   = rd_en_q;
    assign o_rd_addr = rd_addr_q;
    assign o_busy    = busy_q;
    assign o_done    = done_q;

endmodule

// File: tb/tb_log_ram_reader.sv
// tb_log_ram_reader: directed and randomized checks of log_ram_reader against a
// word-list reference model built from the RAM contents.
module tb_log_ram_reader;

    localparam int NB_ADDR = 10;
    localparam int NB_DATA = 8;
    localparam int DEPTH   = 1 << NB_ADDR;

    logic               clock;
    logic               i_reset;
    logic               i_enable;
    logic               i_start;
    logic [NB_ADDR-1:0] i_last_addr;
    logic               o_rd_en;
    logic [NB_ADDR-1:0] o_rd_addr;
    logic [NB_DATA-1:0] ram_q;
    logic [NB_DATA-1:0] o_data;
    logic               o_valid;
    logic               i_ready;
    logic               o_busy;
    logic               o_done;

    logic [NB_DATA-1:0] mem [0:DEPTH-1];

    logic [NB_DATA-1:0] got[$];
    int                 got_cyc[$];
    logic [NB_DATA-1:0] exp_q[$];

    int cycle;
    int first_valid;
    int prev_addr;
    bit wrapped;
    int n_checks;
    int n_pass;
    int n_fail;

    log_ram_reader #(
        .NB_ADDR (NB_ADDR),
        .NB_DATA (NB_DATA)
    ) dut (
        .clock       (clock),
        .i_reset     (i_reset),
        .i_enable    (i_enable),
        .i_start     (i_start),
        .i_last_addr (i_last_addr),
        .o_rd_en     (o_rd_en),
        .o_rd_addr   (o_rd_addr),
        .i_rd_data   (ram_q),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous-read RAM with one cycle of read latency.
    always @(posedge clock) begin
        if (o_rd_en) ram_q <= mem[o_rd_addr];
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] outs();
        return {10'd0, o_rd_en, o_valid, o_busy, o_done, o_rd_addr, o_data};
    endfunction

    // Reference: the words a full readout must deliver, straight from RAM contents.
    function automatic void build_exp(input int last);
        logic [NB_DATA-1:0] x;
        x = '0;
        exp_q.delete();
        for (int a = 0; a <= last; a++) begin
            exp_q.push_back(mem[a]);
            x ^= mem[a];
        end
`ifdef LOG_READER_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endfunction

    function automatic void new_run();
        got.delete();
        got_cyc.delete();
        first_valid = -1;
        prev_addr   = 0;
        wrapped     = 1'b0;
    endfunction

    // One clock: record a transfer if the handshake is set up before the edge.
    task automatic step();
        logic               hs;
        logic [NB_DATA-1:0] d;
        hs = o_valid && i_ready && i_enable;
        d  = o_data;
        @(posedge clock);
        #1;
        cycle++;
        if (hs) begin
            got.push_back(d);
            got_cyc.push_back(cycle);
        end
        if (o_valid && first_valid < 0) first_valid = cycle;
        if (o_busy && int'(o_rd_addr) < prev_addr) wrapped = 1'b1;
        prev_addr = int'(o_rd_addr);
    endtask

    task automatic start(input int last);
        i_last_addr = NB_ADDR'(last);
        i_start     = 1'b1;
        step();
        i_start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (!o_done && n < budget) begin
            step();
            n++;
        end
        check({tag, "_done"}, o_done, 1);
        check({tag, "_busy"}, o_busy, 0);
    endtask

    task automatic compare(input string tag);
        int bad;
        bad = 0;
        check({tag, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            if (got[i] !== exp_q[i]) bad++;
        end
        check({tag, "_words"}, bad, 0);
    endtask

    // Freeze for n cycles; every output must hold exactly.
    task automatic freeze(input string tag, input int n);
        logic [31:0] snap;
        int          bad;
        snap     = outs();
        bad      = 0;
        i_enable = 1'b0;
        repeat (n) begin
            step();
            if (outs() !== snap) bad++;
        end
        i_enable = 1'b1;
        check({tag, "_hold"}, bad, 0);
    endtask

    initial begin
        int n;
        int bad;
        int start_cyc;
        int last;

        n_checks    = 0;
        n_pass      = 0;
        n_fail      = 0;
        cycle       = 0;
        i_reset     = 1'b1;
        i_enable    = 1'b1;
        i_start     = 1'b0;
        i_last_addr = '0;
        i_ready     = 1'b0;
        for (int a = 0; a < DEPTH; a++) mem[a] = NB_DATA'(a) ^ 8'hA5;
        new_run();

        // Reset state
        #22;
        check("rst_hold", outs(), 0);
        i_reset = 1'b0;
        step();
        step();
        check("rst_idle", outs(), 0);

        // A: four words, ready high; latency 2, throughput 3
        build_exp(3);
        new_run();
        i_ready = 1'b1;
        start(3);
        start_cyc = cycle;
        wait_done("a", 100);
        compare("a");
        check("a_first", exp_q[0], 8'hA5);
        check("a_latency", first_valid - start_cyc, 2);
        bad = 0;
        for (int i = 1; i <= 3 && i < got_cyc.size(); i++) begin
            if (got_cyc[i] - got_cyc[i-1] != 3) bad++;
        end
        check("a_spacing", bad, 0);
        check("a_last_addr", o_rd_addr, 3);

        // B: consumer stalls 10 cycles on word 1; restart from DONE
        build_exp(3);
        new_run();
        start(3);
        n = 0;
        while (!(got.size() == 1 && o_valid) && n < 50) begin
            step();
            n++;
        end
        check("b_reach", got.size() == 1 && o_valid, 1);
        i_ready = 1'b0;
        bad = 0;
        repeat (10) begin
            step();
            if (!(o_valid === 1'b1 && o_data === 8'hA4)) bad++;
        end
        check("b_stall", bad, 0);
        i_ready = 1'b1;
        wait_done("b", 100);
        compare("b");

        // E: freezes during READ, WAIT and PRESENT with ready high
        build_exp(3);
        new_run();
        start(3);
        freeze("e_read", 2);
        n = 0;
        while (!(o_busy && !o_rd_en && !o_valid) && n < 20) begin
            step();
            n++;
        end
        freeze("e_wait", 5);
        n = 0;
        while (!(got.size() == 1 && o_valid) && n < 20) begin
            step();
            n++;
        end
        check("e_reach", got.size() == 1 && o_valid, 1);
        freeze("e_pres", 5);
        wait_done("e", 100);
        compare("e");

        // F: start and last-address changes while busy are ignored
        build_exp(3);
        new_run();
        start(3);
        i_start     = 1'b1;
        i_last_addr = NB_ADDR'(7);
        repeat (4) step();
        i_start = 1'b0;
        wait_done("f", 100);
        compare("f");

        // D: asynchronous reset during PRESENT of word 2, then restart
        build_exp(3);
        new_run();
        start(3);
        n = 0;
        while (!(got.size() == 2 && o_valid) && n < 50) begin
            step();
            n++;
        end
        check("d_reach", got.size() == 2 && o_valid, 1);
        #2 i_reset = 1'b1;
        #1;
        check("d_async", outs(), 0);
        #2 i_reset = 1'b0;
        bad = 0;
        repeat (5) begin
            step();
            if (o_valid !== 1'b0) bad++;
        end
        check("d_no_partial", bad, 0);
        check("d_no_xfer", got.size(), 2);
        new_run();
        start(3);
        wait_done("d", 100);
        compare("d");

        // Single word
        build_exp(0);
        new_run();
        start(0);
        wait_done("one", 50);
        compare("one");

        // G: random sizes, random ready and enable, noise on start/last while busy
        for (int it = 0; it < 4; it++) begin
            last = int'($urandom_range(0, 12));
            build_exp(last);
            new_run();
            start(last);
            n = 0;
            while (!o_done && n < 600) begin
                i_ready     = 1'($urandom_range(0, 1));
                i_enable    = ($urandom_range(0, 3) != 0);
                i_start     = o_busy ? 1'($urandom_range(0, 1)) : 1'b0;
                i_last_addr = NB_ADDR'($urandom);
                step();
                n++;
            end
            i_enable = 1'b1;
            i_start  = 1'b0;
            i_ready  = 1'b1;
            check("g_done", o_done, 1);
            compare("g");
        end

        // C: full RAM of random data, no address wrap
        for (int a = 0; a < DEPTH; a++) mem[a] = NB_DATA'($urandom);
        build_exp(DEPTH - 1);
        new_run();
        start(DEPTH - 1);
        wait_done("c", 4000);
        compare("c");
        check("c_no_wrap", wrapped, 0);
        check("c_last_addr", o_rd_addr, DEPTH - 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
